// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-256 encrypt core.
//   NR / BLOCK_BITS  : round count and state width
//   fsm_t            : sequencer state encoding
//   SBOX, sbox()     : forward S-box lookup
//   gf_xtime/gf_mul2/gf_mul3 : GF(2^8) helpers for MixColumns
//   rk_lsb()         : LSB of round key i inside the concatenated {k1..k13} bus
package aes_pkg;
  localparam int NR          = 14;
  localparam int BLOCK_BITS  = 128;
  localparam int KEY_BITS    = 256;
  localparam int RK_BUS_BITS = (NR - 1) * BLOCK_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_KEYS = 2'd1,
    ROUND     = 2'd2,
    DONE      = 2'd3
  } fsm_t;

  // rk2 sits in the top slice of the bus, rk14 in the bottom one.
  function automatic int rk_lsb(input int i);
    return (NR - i) * BLOCK_BITS;
  endfunction

  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return gf_xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return gf_xtime(b) ^ b;
  endfunction
endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes -> ShiftRows -> MixColumns -> AddRoundKey.
//   state_in    : 128-bit state, byte 0 in [127:120], column-major
//   round_key   : key added at the end of the round
//   final_round : bypass MixColumns (last cipher round)
//   state_out   : resulting state
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);
  // Element 0 maps to the MSB byte so index i is AES byte i.
  logic [0:15][7:0] in_b, sb_b, sr_b, mc_b;

  assign in_b = state_in;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    assign sb_b[i] = sbox(in_b[i]);
  end

  // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4).
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_b[4*c+r] = sb_b[4*((c+r)%4)+r];
    end
    assign mc_b[4*c+0] = gf_mul2(sr_b[4*c]) ^ gf_mul3(sr_b[4*c+1]) ^ sr_b[4*c+2] ^ sr_b[4*c+3];
    assign mc_b[4*c+1] = sr_b[4*c] ^ gf_mul2(sr_b[4*c+1]) ^ gf_mul3(sr_b[4*c+2]) ^ sr_b[4*c+3];
    assign mc_b[4*c+2] = sr_b[4*c] ^ sr_b[4*c+1] ^ gf_mul2(sr_b[4*c+2]) ^ gf_mul3(sr_b[4*c+3]);
    assign mc_b[4*c+3] = gf_mul3(sr_b[4*c]) ^ sr_b[4*c+1] ^ sr_b[4*c+2] ^ gf_mul2(sr_b[4*c+3]);
  end

  assign state_out = (final_round ? sr_b : mc_b) ^ round_key;
endmodule

// File: rtl/aes256_encrypt_core.sv
// Iterative AES-256 encrypt core with start/busy/done handshake.
//   clock, reset_n : rising-edge clock, async active-low reset
//   start          : one-cycle request, accepted only in IDLE
//   cipher_key     : rk0 = [255:128], rk1 = [127:0]
//   round_keys     : {k1..k13} = rk2..rk14, rk2 in the top slice
//   keys_valid     : key material stable; accept waits for it
//   plaintext      : sampled on the accept edge only
//   ciphertext     : result, held until the next completion
//   busy / done    : busy from accept to done; done is a one-cycle pulse
// Build option AES_TWO_ROUNDS_PER_CYCLE_EN: two rounds per clock (7 round edges).
module aes256_encrypt_core
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 14,
  parameter int BLOCK_BITS = 128
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [KEY_BITS-1:0]    cipher_key,
  input  logic [RK_BUS_BITS-1:0] round_keys,
  input  logic                   keys_valid,
  input  logic [127:0]           plaintext,
  output logic [127:0]           ciphertext,
  output logic                   busy,
  output logic                   done
);
  if (NUM_ROUNDS != NR || BLOCK_BITS != aes_pkg::BLOCK_BITS) begin : g_param_err
    $error("aes256_encrypt_core supports only NUM_ROUNDS=14, BLOCK_BITS=128");
  end

`ifdef AES_TWO_ROUNDS_PER_CYCLE_EN
  localparam logic [3:0] CTR_STEP = 4'd2;
  localparam logic [3:0] LAST_CTR = 4'(NR - 1);
`else
  localparam logic [3:0] CTR_STEP = 4'd1;
  localparam logic [3:0] LAST_CTR = 4'(NR);
`endif

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_reg, state_reg_d;
  logic [127:0] latched_pt, latched_pt_d;
  logic [127:0] ciphertext_d;
  logic [3:0]   round_ctr, round_ctr_d;
  logic         busy_d, done_d;

  // Round-key table indexed directly by round_ctr.
  logic [NR:0][127:0] rk;
  assign rk[0] = cipher_key[255:128];
  assign rk[1] = cipher_key[127:0];
  for (genvar i = 2; i <= NR; i++) begin : g_rk
    assign rk[i] = round_keys[rk_lsb(i) +: 128];
  end

  logic [127:0] round_a, round_res;

  aes_round u_round_a (
    .state_in    (state_reg),
    .round_key   (rk[round_ctr]),
    .final_round (round_ctr == 4'(NR)),
    .state_out   (round_a)
  );

`ifdef AES_TWO_ROUNDS_PER_CYCLE_EN
  // Second stage handles round r+1; it is the last round when r = 13.
  logic [127:0] round_b;
  aes_round u_round_b (
    .state_in    (round_a),
    .round_key   (rk[round_ctr + 4'd1]),
    .final_round (round_ctr == 4'(NR - 1)),
    .state_out   (round_b)
  );
  assign round_res = round_b;
`else
  assign round_res = round_a;
`endif

  always_comb begin
    fsm_d        = fsm_q;
    state_reg_d  = state_reg;
    latched_pt_d = latched_pt;
    ciphertext_d = ciphertext;
    round_ctr_d  = round_ctr;
    busy_d       = busy;
    done_d       = 1'b0;
    unique case (fsm_q)
      IDLE: if (start) begin
        busy_d = 1'b1;
        if (keys_valid) begin
          state_reg_d = plaintext ^ rk[0];
          round_ctr_d = 4'd1;
          fsm_d       = ROUND;
        end else begin
          latched_pt_d = plaintext;
          fsm_d        = WAIT_KEYS;
        end
      end
      WAIT_KEYS: if (keys_valid) begin
        state_reg_d = latched_pt ^ rk[0];
        round_ctr_d = 4'd1;
        fsm_d       = ROUND;
      end
      ROUND: begin
        state_reg_d = round_res;
        round_ctr_d = round_ctr + CTR_STEP;
        if (round_ctr == LAST_CTR) fsm_d = DONE;
      end
      DONE: begin
        ciphertext_d = state_reg;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        fsm_d        = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q      <= IDLE;
      state_reg  <= '0;
      latched_pt <= '0;
      ciphertext <= '0;
      round_ctr  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_reg  <= state_reg_d;
      latched_pt <= latched_pt_d;
      ciphertext <= ciphertext_d;
      round_ctr  <= round_ctr_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end
endmodule

// File: tb/tb_aes256_encrypt_core.sv
// Self-checking bench for aes256_encrypt_core against a byte-level AES-256 model.
module tb_aes256_encrypt_core;
  logic           clock = 1'b0;
  logic           reset_n;
  logic           start;
  logic [255:0]   cipher_key;
  logic [1663:0]  round_keys;
  logic           keys_valid;
  logic [127:0]   plaintext;
  logic [127:0]   ciphertext;
  logic           busy;
  logic           done;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_TWO_ROUNDS_PER_CYCLE_EN
  localparam int LAT = 8;   // edges from accept to done
`else
  localparam int LAT = 15;
`endif

  aes256_encrypt_core dut (
    .clock(clock), .reset_n(reset_n), .start(start), .cipher_key(cipher_key),
    .round_keys(round_keys), .keys_valid(keys_valid), .plaintext(plaintext),
    .ciphertext(ciphertext), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  logic [7:0]   sb [256];
  logic [127:0] m_rk [15];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box derived from the field inverse and affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Expands the key into m_rk and drives the DUT key inputs.
  task automatic set_keys(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc = 8'h01;
    logic [1663:0] bus;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int i = 2; i < 15; i++) bus[(14-i)*128 +: 128] = m_rk[i];
    cipher_key = key;
    round_keys = bus;
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ m_rk[0][127-8*(4*c+r) -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r][c] = sb[s[r][c]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = t[r][(c+r)%4];
      if (rnd < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[0][c]; a1 = s[1][c]; a2 = s[2][c]; a3 = s[3][c];
          s[0][c] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[1][c] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[2][c] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[3][c] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ m_rk[rnd][127-8*(4*c+r) -: 8];
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = s[r][c];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  // Leaves the bench 1 time unit after the accept edge; plaintext then scrambled.
  task automatic do_accept(input logic [127:0] pt);
    start = 1'b1; plaintext = pt;
    @(posedge clock); #1;
    start = 1'b0; plaintext = rand128();
  endtask

  task automatic wait_done(input int maxc, output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (n < maxc) begin
      @(posedge clock); #1;
      n++;
      if (done) begin seen = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b1; start = 1'b0; keys_valid = 1'b0; plaintext = '0;
    cipher_key = '0; round_keys = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (ciphertext !== '0) begin bad++; $display("FAIL reset_ct got=%h want=0", ciphertext); end
    reset_n = 1'b1;
    @(posedge clock); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle busy=%b done=%b want 0/0", busy, done); end
  endtask

  task automatic test_fips_c3();
    int n; bit seen;
    set_keys(C3_KEY); keys_valid = 1'b1;
    do_accept(C3_PT);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL c3_busy got=%b want=1", busy); end
    wait_done(40, n, seen);
    total++; if (!seen || n != LAT) begin
      bad++; $display("FAIL c3_latency got=%0d seen=%0d want=%0d", n, seen, LAT); end
    total++; if (ciphertext !== C3_CT) begin
      bad++; $display("FAIL c3_ct got=%h want=%h", ciphertext, C3_CT); end
    total++; if (ciphertext !== model_enc(C3_PT)) begin
      bad++; $display("FAIL c3_model got=%h want=%h", ciphertext, model_enc(C3_PT)); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL c3_busy_at_done got=%b want=0", busy); end
    @(posedge clock); #1;
    total++; if (done !== 1'b0 || ciphertext !== C3_CT) begin
      bad++; $display("FAIL c3_after_done done=%b ct=%h want 0/%h", done, ciphertext, C3_CT); end
  endtask

  task automatic test_keys_late();
    int n; bit busy_ok;
    keys_valid = 1'b0;
    set_keys({rand128(), rand128()});   // garbage while not valid
    do_accept(C3_PT);
    busy_ok = (busy === 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
    end
    set_keys(C3_KEY); keys_valid = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    total++; if (!busy_ok) begin bad++; $display("FAIL late_busy_held got=0 want=1"); end
    total++; if (done !== 1'b1 || n != LAT + 1) begin
      bad++; $display("FAIL late_latency got=%0d done=%b want=%0d", n, done, LAT + 1); end
    total++; if (ciphertext !== C3_CT) begin
      bad++; $display("FAIL late_ct got=%h want=%h", ciphertext, C3_CT); end
  endtask

  task automatic test_start_busy();
    int pulses = 0; int first = -1; logic [127:0] ct_first = '0;
    set_keys(C3_KEY); keys_valid = 1'b1;
    do_accept(C3_PT);
    for (int i = 1; i <= 45; i++) begin
      if (i == 8) begin start = 1'b1; plaintext = '1; end
      if (i == 9) start = 1'b0;
      @(posedge clock); #1;
      if (done) begin
        pulses++;
        if (first < 0) begin first = i; ct_first = ciphertext; end
      end
    end
    total++; if (pulses != 1 || first != LAT) begin
      bad++; $display("FAIL busy_start_pulses got=%0d at %0d want=1 at %0d", pulses, first, LAT); end
    total++; if (ct_first !== C3_CT || ciphertext !== C3_CT) begin
      bad++; $display("FAIL busy_start_ct got=%h want=%h", ct_first, C3_CT); end
  endtask

  task automatic test_reset_mid();
    int n; bit seen;
    int mid = (LAT > 9) ? 9 : 4;
    set_keys(C3_KEY); keys_valid = 1'b1;
    do_accept(rand128());
    repeat (mid) @(posedge clock);
    #1 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (ciphertext !== '0) begin bad++; $display("FAIL midrst_ct got=%h want=0", ciphertext); end
    @(posedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    do_accept(C3_PT);
    wait_done(40, n, seen);
    total++; if (!seen || n != LAT || ciphertext !== C3_CT) begin
      bad++; $display("FAIL midrst_rerun got=%h n=%0d want=%h n=%0d", ciphertext, n, C3_CT, LAT); end
  endtask

  task automatic test_back_to_back();
    int n = 0; bit held_ok = 1'b1; bit quiet = 1'b1;
    set_keys(C3_KEY); keys_valid = 1'b1;
    do_accept(C3_PT);
    for (int e = 1; e < LAT; e++) begin
      @(posedge clock); #1;
      if (done !== 1'b0) quiet = 1'b0;
    end
    start = 1'b1; plaintext = '1;          // lands in the DONE cycle: ignored
    @(posedge clock); #1;
    total++; if (!quiet || done !== 1'b1 || busy !== 1'b0 || ciphertext !== C3_CT) begin
      bad++; $display("FAIL b2b_first_done done=%b busy=%b ct=%h want 1/0/%h", done, busy, ciphertext, C3_CT); end
    plaintext = '0;                        // accepted on the edge after done
    @(posedge clock); #1;
    start = 1'b0; plaintext = rand128();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b want=1", busy); end
    while (n < 40) begin
      @(posedge clock); #1;
      n++;
      if (done) break;
      if (ciphertext !== C3_CT) held_ok = 1'b0;
    end
    total++; if (!held_ok) begin bad++; $display("FAIL b2b_hold got=changed want=%h", C3_CT); end
    total++; if (done !== 1'b1 || n != LAT) begin
      bad++; $display("FAIL b2b_latency got=%0d want=%0d", n, LAT); end
    total++; if (ciphertext !== model_enc('0)) begin
      bad++; $display("FAIL b2b_ct got=%h want=%h", ciphertext, model_enc('0)); end
  endtask

  task automatic test_random();
    int n; bit seen; logic [127:0] pt, exp;
    for (int k = 0; k < 6; k++) begin
      set_keys({rand128(), rand128()}); keys_valid = 1'b1;
      pt  = rand128();
      exp = model_enc(pt);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
      do_accept(pt);
      wait_done(40, n, seen);
      total++; if (!seen || n != LAT) begin
        bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", k, n, LAT); end
      total++; if (ciphertext !== exp) begin
        bad++; $display("FAIL rand_ct[%0d] got=%h want=%h", k, ciphertext, exp); end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_c3();
    test_keys_late();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
